// File: rtl/hazard_forward_unit.sv
// Load-use stall detection and EX operand forwarding, driven by a three-stage
// shadow copy (EX/MEM/WB) of the core pipeline.
module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int ZERO_REG = 31,
  parameter int NSRC     = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [NSRC*AW-1:0]  id_src,
  input  logic [NSRC-1:0]     id_src_used,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic                flush,
  input  logic                stat_clr,
  output logic                stall_id,
  output logic [2*NSRC-1:0]   fwd_sel,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [AW-1:0] ZeroIdx = AW'(ZERO_REG);

  logic               exValid;
  logic [NSRC*AW-1:0] exSrc;
  logic [NSRC-1:0]    exSrcUsed;
  logic [AW-1:0]      exRd;
  logic               exRegwrite;
  logic               exMemread;

  logic               memValid;
  logic [AW-1:0]      memRd;
  logic               memRegwrite;

  logic               wbValid;
  logic [AW-1:0]      wbRd;
  logic               wbRegwrite;

  logic exWriting;
  logic memWriting;
  logic wbWriting;
  logic srcHit;

  assign exWriting  = exValid  && exRegwrite  && (exRd  != ZeroIdx);
  assign memWriting = memValid && memRegwrite && (memRd != ZeroIdx);
  assign wbWriting  = wbValid  && wbRegwrite  && (wbRd  != ZeroIdx);

  always_comb begin
    srcHit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_used[i] && (id_src[i*AW +: AW] == exRd)) srcHit = 1'b1;
    end
  end

  // Flush wins over the stall: the consumer is being killed anyway.
  assign stall_id = id_valid && !flush && exWriting && exMemread && srcHit;

  // MEM is the younger producer, so it is checked first.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (exValid && exSrcUsed[i]) begin
        if (memWriting && (memRd == exSrc[i*AW +: AW])) fwd_sel[2*i +: 2] = 2'b10;
        else if (wbWriting && (wbRd == exSrc[i*AW +: AW])) fwd_sel[2*i +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid     <= 1'b0;
      exSrc       <= '0;
      exSrcUsed   <= '0;
      exRd        <= '0;
      exRegwrite  <= 1'b0;
      exMemread   <= 1'b0;
      memValid    <= 1'b0;
      memRd       <= '0;
      memRegwrite <= 1'b0;
      wbValid     <= 1'b0;
      wbRd        <= '0;
      wbRegwrite  <= 1'b0;
    end else begin
      wbValid     <= memValid;
      wbRd        <= memRd;
      wbRegwrite  <= memRegwrite;
      memValid    <= exValid;
      memRd       <= exRd;
      memRegwrite <= exRegwrite;
      exValid     <= id_valid && !stall_id && !flush;
      exSrc       <= id_src;
      exSrcUsed   <= id_src_used;
      exRd        <= id_rd;
      exRegwrite  <= id_regwrite;
      exMemread   <= id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stat_clr) begin
      stall_count <= '0;
    end else if (stall_id && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scenario bench for hazard_forward_unit; a second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        stat_clr;
  logic        stall_id, stall_id2;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       v;
    logic [4:0] s0, s1;
    logic [1:0] used;
    logic [4:0] rd;
    logic       rw, mr, fl, clr;
    logic       expStall;
    logic [3:0] expFwd;
  } row_t;

  typedef struct packed {
    logic        stall;
    logic [3:0]  fwd;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] expCnt;
  logic [1:0]  expCnt2;

  hazard_forward_unit dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .stat_clr(stat_clr),
    .stall_id(stall_id), .fwd_sel(fwd_sel), .stall_count(stall_count)
  );

  hazard_forward_unit #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .stat_clr(stat_clr),
    .stall_id(stall_id2), .fwd_sel(fwd_sel2), .stall_count(stall_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic row_t mk(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                              input logic [1:0] used, input logic [4:0] rd, input logic rw,
                              input logic mr, input logic fl, input logic clr,
                              input logic st, input logic [3:0] fwd);
    row_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.rd = rd; r.rw = rw; r.mr = mr;
    r.fl = fl; r.clr = clr; r.expStall = st; r.expFwd = fwd;
    return r;
  endfunction

  task automatic drive(input row_t r);
    @(negedge clk);
    id_valid = r.v; id_src = {r.s1, r.s0}; id_src_used = r.used; id_rd = r.rd;
    id_regwrite = r.rw; id_memread = r.mr; flush = r.fl; stat_clr = r.clr;
    sb.push_back('{stall: r.expStall, fwd: r.expFwd, cnt: expCnt, cnt2: expCnt2});
  endtask

  task automatic advance(input row_t r);
    @(posedge clk);
    if (r.clr) begin
      expCnt = '0;
      expCnt2 = '0;
    end else if (r.expStall) begin
      if (expCnt != 16'hFFFF) expCnt++;
      if (expCnt2 != 2'd3) expCnt2++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    expCnt = '0;
    expCnt2 = '0;
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rst_n = 1'b0;
    expCnt = '0;
    expCnt2 = '0;
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 5, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL reset.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL reset.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt || stall_count2 !== e.cnt2) begin failures++; $display("FAIL reset.cnt row %0d: got %0d/%0d want %0d/%0d", i, stall_count, stall_count2, e.cnt, e.cnt2); end
      advance(rows[i]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_chain();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 2, 3, 2'b11, 1, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 4, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0010));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL alu_chain.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL alu_chain.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_distance2();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b11, 3, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 9, 10, 2'b11, 8, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 12, 3, 2'b11, 13, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0100));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL distance2.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL distance2.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 3, 4, 2'b11, 1, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 4, 2'b01, 2, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 2, 2'b11, 9, 1, 0, 0, 0, 0, 4'b0010));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b1001));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL back_to_back.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL back_to_back.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b01, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 6, 2'b11, 7, 1, 0, 0, 0, 1, 4'b0000));
    rows.push_back(mk(1, 5, 6, 2'b11, 7, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0001));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL load_use.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL load_use.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt) begin failures++; $display("FAIL load_use.cnt row %0d: got %0d want %0d", i, stall_count, e.cnt); end
      advance(rows[i]);
    end
  endtask

  task automatic test_unused_operand();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 9, 5, 2'b01, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 5, 2'b00, 8, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL unused.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL unused.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_zero_reg();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b00, 31, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 31, 2, 2'b01, 4, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 2, 2'b11, 31, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 31, 31, 2'b11, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL zero_reg.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL zero_reg.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_flush();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 6, 2'b01, 7, 1, 0, 1, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL flush.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL flush.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt) begin failures++; $display("FAIL flush.cnt row %0d: got %0d want %0d", i, stall_count, e.cnt); end
      advance(rows[i]);
    end
  endtask

  task automatic test_mem_wb_priority();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b11, 7, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 3, 4, 2'b11, 7, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 7, 7, 2'b11, 8, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b1010));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL priority.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL priority.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      advance(rows[i]);
    end
  endtask

  task automatic test_saturation_clear();
    row_t rows[$];
    exp_t e;
    doReset();
    for (int k = 0; k < 6; k++) begin
      rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, (k == 0) ? 4'b0000 : 4'b0001));
      rows.push_back(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, (k == 5), 1, 4'b0000));
      rows.push_back(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0, 4'b0000));
    end
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0001));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL saturate.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL saturate.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt || stall_count2 !== e.cnt2) begin failures++; $display("FAIL saturate.cnt row %0d: got %0d/%0d want %0d/%0d", i, stall_count, stall_count2, e.cnt, e.cnt2); end
      advance(rows[i]);
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    exp_t e;
    doReset();
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1, 4'b0000));
    rows.push_back(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(1, 1, 2, 2'b00, 5, 1, 1, 0, 0, 0, 4'b0001));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL reset_mid.stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL reset_mid.fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt) begin failures++; $display("FAIL reset_mid.cnt row %0d: got %0d want %0d", i, stall_count, e.cnt); end
      advance(rows[i]);
    end
    // Consumer of the in-flight load is presented, then reset hits mid-cycle.
    drive(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 1, 4'b0000));
    #2;
    e = sb.pop_front();
    checks++; if (stall_id !== e.stall) begin failures++; $display("FAIL reset_mid.pre_stall: got %b want %b", stall_id, e.stall); end
    rst_n = 1'b0;
    #1;
    expCnt = '0;
    expCnt2 = '0;
    checks++; if (stall_id !== 1'b0 || stall_id2 !== 1'b0) begin failures++; $display("FAIL reset_mid.async_stall: got %b/%b want 0", stall_id, stall_id2); end
    checks++; if (stall_count !== expCnt || stall_count2 !== expCnt2) begin failures++; $display("FAIL reset_mid.async_cnt: got %0d/%0d want 0", stall_count, stall_count2); end
    @(negedge clk);
    rst_n = 1'b1;
    rows.delete();
    rows.push_back(mk(1, 5, 0, 2'b01, 6, 1, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    rows.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 4'b0000));
    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i]);
      #2;
      e = sb.pop_front();
      checks++; if (stall_id !== e.stall || stall_id2 !== e.stall) begin failures++; $display("FAIL reset_mid.post_stall row %0d: got %b/%b want %b", i, stall_id, stall_id2, e.stall); end
      checks++; if (fwd_sel !== e.fwd || fwd_sel2 !== e.fwd) begin failures++; $display("FAIL reset_mid.post_fwd row %0d: got %b/%b want %b", i, fwd_sel, fwd_sel2, e.fwd); end
      checks++; if (stall_count !== e.cnt) begin failures++; $display("FAIL reset_mid.post_cnt row %0d: got %0d want %0d", i, stall_count, e.cnt); end
      advance(rows[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_src = '0; id_src_used = '0; id_rd = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; flush = 1'b0; stat_clr = 1'b0;
    expCnt = '0;
    expCnt2 = '0;
    test_reset();
    test_alu_chain();
    test_distance2();
    test_back_to_back();
    test_load_use();
    test_unused_operand();
    test_zero_reg();
    test_flush();
    test_mem_wb_priority();
    test_saturation_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter AW, default 5, register-address width.
REQ-002 Parameter ZERO_REG, default 31, hard-wired zero register index; never forwarded or stalled on.
REQ-003 Parameter NSRC, default 2, number of source operands per instruction (1..4).
REQ-004 Parameter CNT_W, default 16, stall-counter width.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID stage holds a real instruction.
REQ-008 id_src  in  NSRC*AW  ID source register indices; operand i in bits [i*AW +: AW].
REQ-009 id_src_used  in  NSRC  per-operand "source actually read" flag.
REQ-010 id_rd  in  AW  ID destination register.
REQ-011 id_regwrite  in  1  ID instruction writes id_rd.
REQ-012 id_memread  in  1  ID instruction is a load.
REQ-013 flush  in  1  branch flush: kill the ID instruction this cycle.
REQ-014 stat_clr  in  1  synchronous clear of stall_count.
REQ-015 stall_id  out  1  hold PC and IF/ID; insert a bubble into EX.
REQ-016 fwd_sel  out  2*NSRC  per EX operand: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
REQ-017 stall_count  out  CNT_W  number of load-use stall cycles since reset or clear.

Function
REQ-018 The block shall keep an internal shadow pipeline of three stages, EX, MEM and WB.
- EX holds: valid, src[NSRC], src_used, rd, regwrite, memread.
- MEM and WB hold: valid, rd, regwrite.
REQ-019 The shadow pipeline shall advance every cycle: WB<=MEM, MEM<=EX, EX<=ID.
- If stall_id or flush is 1, EX shall load a bubble (valid=0) instead of the ID instruction.
REQ-020 A stage shall be "writing" only if valid=1, regwrite=1 and rd!=ZERO_REG.
REQ-021 fwd_sel[i] shall be combinational from registered state only, evaluated against EX src[i] with src_used[i]=1 and EX valid=1:
- 10 if MEM is writing and MEM rd == src[i];
- else 01 if WB is writing and WB rd == src[i];
- else 00.
REQ-022 When MEM and WB both match the same operand, MEM shall take priority (10).
REQ-023 stall_id shall be 1 when all of the following hold:
- id_valid=1;
- flush=0;
- EX is writing with memread=1;
- some operand i has id_src_used[i]=1 and id_src[i] == EX rd.
REQ-024 A load-use stall shall last exactly one cycle. The bubble removes the load from EX, and the consumer is then served by MEM/WB forwarding (01) on its EX cycle.
REQ-025 flush shall have priority over stall_id: stall_id=0 and EX receives a bubble. MEM and WB are unaffected.
REQ-026 stall_count shall increment by 1 on each cycle with stall_id=1.
- It shall saturate at 2^CNT_W-1.
- stat_clr=1 shall set it to 0 and take priority over increment.
REQ-027 An operand with id_src_used=0 shall never cause a stall or a non-zero fwd_sel, whatever its index value.
REQ-028 Reads of the WB-stage destination in ID are out of scope: the register file is write-before-read.

Reset
REQ-029 While rst_n=0, all stage valid bits shall be 0 and stall_count shall be 0. fwd_sel is then all 00 and stall_id is 0, independent of clk.
REQ-030 Reset asserted mid-operation shall discard all in-flight entries. After rst_n rises, no forward or stall shall reference a pre-reset instruction.

Verification
REQ-031 ALU chain: ADD X1 (rd=1, regwrite) followed by SUB using X1 as src0 -> on SUB's EX cycle fwd_sel[1:0]=10, stall_id never 1.
REQ-032 Distance-2 dependency: writer rd=3, one unrelated instruction, then reader src1=3 -> fwd_sel[3:2]=01 on reader's EX cycle.
REQ-033 Load-use: LDUR rd=5 (memread) followed by reader src0=5 ->
- stall_id=1 for exactly one cycle, stall_count 0->1;
- reader's EX cycle then shows fwd_sel[1:0]=01.
REQ-034 Zero register: writer rd=31, reader src0=31, including as a load -> fwd_sel=00, stall_id=0.
REQ-035 Flush during a load-use condition -> stall_id=0, stall_count unchanged, next EX valid=0.
REQ-036 Both MEM and WB write rd=7, EX src0=7 -> 10. With CNT_W=2 and 5 stalls -> stall_count=3. stat_clr during a stall -> 0.
